// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, widths and types for the VGA timing generator.
// The defaults describe the standard 640x480 @ 60 Hz mode (800 x 525 totals).
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int DATA_LAT_DEF = 2;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Internal timing flags are active-high so a cleared pipeline means "blank, no sync".
  typedef struct packed {
    logic visible;
    logic h_sync;
    logic v_sync;
  } timing_t;

  function automatic logic in_window(cnt_t pos, cnt_t lo, cnt_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-client link: the generator issues coordinates, the client returns colour
// for each coordinate a fixed number of clocks later.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  cnt_t   oCoord_X;
  cnt_t   oCoord_Y;
  logic   oRequest;
  logic   oFrame_Start;
  color_t iRed;
  color_t iGreen;
  color_t iBlue;

  modport master (
    output oCoord_X, oCoord_Y, oRequest, oFrame_Start,
    input  iRed, iGreen, iBlue
  );

  modport slave (
    input  oCoord_X, oCoord_Y, oRequest, oFrame_Start,
    output iRed, iGreen, iBlue
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear, used to align the timing
// flags with the client's colour latency.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is cleared, not just the head; stale flags here would
  // emit a false sync or visible pixel right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: issues pixel coordinates to a client and drives
// the DAC with the returned colour, syncs and blank aligned to the same edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int DATA_LAT = DATA_LAT_DEF
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  vga_timing_gen_if.master client,
  output color_t           oVGA_R,
  output color_t           oVGA_G,
  output color_t           oVGA_B,
  output logic             oVGA_H_SYNC,
  output logic             oVGA_V_SYNC,
  output logic             oVGA_BLANK,
  output logic             oVGA_SYNC
);

  localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FRONT);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FRONT);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);

  cnt_t    h_q, h_d;
  cnt_t    v_q, v_d;
  cnt_t    x_q, y_q;
  logic    req_q, fs_q;
  timing_t timing_d, timing_q, timing_dl;

  color_t  r_q, g_q, b_q;
  logic    hs_n_q, vs_n_q, blank_n_q;

  // NOTE: all next-state values get a default first so no path leaves them
  // unassigned and infers a latch.
  always_comb begin
    h_d = h_q + cnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end
    timing_d.visible = (h_q < H_VIS) && (v_q < V_VIS);
    timing_d.h_sync  = in_window(h_q, HS_START, HS_END);
    timing_d.v_sync  = in_window(v_q, VS_START, VS_END);
  end

  // Raster counters and the issued-coordinate stage share one register bank.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_q      <= '0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      req_q    <= 1'b0;
      fs_q     <= 1'b0;
      timing_q <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      x_q      <= timing_d.visible ? h_q : '0;
      y_q      <= timing_d.visible ? v_q : '0;
      req_q    <= timing_d.visible;
      fs_q     <= (h_q == '0) && (v_q == '0);
      timing_q <= timing_d;
    end
  end

  assign client.oCoord_X     = x_q;
  assign client.oCoord_Y     = y_q;
  assign client.oRequest     = req_q;
  assign client.oFrame_Start = fs_q;

  // Flags travel DATA_LAT clocks to meet the client's colour, then share the
  // output register with it.
  vga_delay_line #(
    .WIDTH ($bits(timing_t)),
    .DEPTH (DATA_LAT)
  ) u_align (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .d_i   (timing_q),
    .q_o   (timing_dl)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= timing_dl.visible ? client.iRed   : '0;
      g_q       <= timing_dl.visible ? client.iGreen : '0;
      b_q       <= timing_dl.visible ? client.iBlue  : '0;
      hs_n_q    <= ~timing_dl.h_sync;
      vs_n_q    <= ~timing_dl.v_sync;
      blank_n_q <= timing_dl.visible;
    end
  end

  assign oVGA_R      = r_q;
  assign oVGA_G      = g_q;
  assign oVGA_B      = b_q;
  assign oVGA_H_SYNC = hs_n_q;
  assign oVGA_V_SYNC = vs_n_q;
  assign oVGA_BLANK  = blank_n_q;
  assign oVGA_SYNC   = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porches and sync width in clocks (line total 800).
REQ-003 Parameters V_ACTIVE / V_FRONT / V_SYNC / V_BACK, defaults 480 / 10 / 2 / 33, in lines (frame total 525).
REQ-004 Parameter DATA_LAT, default 2, range 1..7, clocks from coordinate issue to pixel data valid on iRed/iGreen/iBlue.
REQ-005 iCLK  input  1  pixel clock; one clock domain, all logic on its rising edge.
REQ-006 iRST_N  input  1  reset, asynchronous, active-low.
REQ-007 iRed, iGreen, iBlue  input  10 each  pixel colour returned by the client for a previously issued coordinate.
REQ-008 oCoord_X, oCoord_Y  output  10 each  pixel coordinate requested from the client.
REQ-009 oRequest  output  1  high when oCoord_X/Y is a visible pixel.
REQ-010 oFrame_Start  output  1  one-cycle pulse with coordinate (0,0).
REQ-011 oVGA_R, oVGA_G, oVGA_B  output  10 each  colour to DAC.
REQ-012 oVGA_H_SYNC, oVGA_V_SYNC  output  1 each  syncs, active-low.
REQ-013 oVGA_BLANK  output  1  active-low blank (high = visible pixel).
REQ-014 oVGA_SYNC  output  1  composite sync to DAC, constant 0.

Function
REQ-015 Horizontal counter h counts 0..799 every clock, wrapping to 0; vertical counter v increments when h wraps, counts 0..524, wrapping to 0.
REQ-016 Line order: active (h 0..639), front porch, sync (h 656..751), back porch; frame order likewise on v (sync v 490..491).
REQ-017 oCoord_X/Y, oRequest, oFrame_Start are registered from (h,v): visible in the clock after the counter value; coordinates equal h/v when both are active, else 0.
REQ-018 oRequest is high exactly when h<H_ACTIVE and v<V_ACTIVE; oFrame_Start is high only for h=0,v=0.
REQ-019 Sync and blank are derived at counter stage, then delayed DATA_LAT+1 clocks, so that they change on the same edge as the colour for that position.
REQ-020 Colour inputs sampled on edge DATA_LAT after a coordinate is issued are registered to oVGA_R/G/B when the delayed blank marks the pixel visible; otherwise oVGA_R/G/B are 0.
REQ-021 Pixel requested during cycle n appears on oVGA_R/G/B during cycle n+DATA_LAT+1, with its syncs/blank.
REQ-022 Sync/blank polarity and widths are independent of client data; iRed/iGreen/iBlue content never affects timing.
REQ-023 Parameter arithmetic: all counters 10 bits; totals above 1023 are illegal and not supported.

Reset
REQ-024 While iRST_N low: h=0, v=0, all delay stages cleared; oCoord_X/Y=0, oRequest=0, oFrame_Start=0, oVGA_R/G/B=0, oVGA_H_SYNC=1, oVGA_V_SYNC=1, oVGA_BLANK=0, oVGA_SYNC=0.
REQ-025 Reset asserted mid-frame takes effect immediately (asynchronous); after release, the first clock edge issues coordinate (0,0) with oFrame_Start=1.
REQ-026 Delay-line contents after reset are inactive values, so no false sync or visible pixel occurs during the first DATA_LAT+1 clocks.

Structure
REQ-027 Timing defaults (porches, sync widths, totals) and colour width constant live in shared package vga_timing_pkg.
REQ-028 Sync/blank alignment uses one sub-module, vga_delay_line (parameterised width and depth, async active-low clear).

Verification
REQ-029 Reset release -> first clock oCoord=(0,0), oRequest=1, oFrame_Start=1; all outputs held at REQ-024 values during reset.
REQ-030 Run one line -> oVGA_H_SYNC low exactly 96 of 800 clocks, oVGA_BLANK high 640 contiguous clocks, sync falling edge 656 clocks after blank rises.
REQ-031 Run two frames -> 525 lines/frame, oVGA_V_SYNC low for 1600 clocks, oFrame_Start period 420000 clocks.
REQ-032 Client model returns iRed = oCoord_X delayed DATA_LAT (DATA_LAT=2 and 5) -> oVGA_R equals x for every visible pixel, 0 in blanking; pixel x=0 coincides with oVGA_BLANK rising.
REQ-033 Assert iRST_N low at h=300,v=200 -> outputs go to reset values without a clock edge; restart at (0,0).
REQ-034 Counter at h=799,v=524 -> next issued coordinate (0,0) with oFrame_Start pulse, no extra or missing line.
